// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and the divide-by-zero quotient constant.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_MAX_W = 64;

  // Quotient reported on divide-by-zero; callers truncate it to their operand width.
  localparam logic [DIV_MAX_W-1:0] DIV_DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference when it is non-negative, otherwise restore.
module div_step #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic         dividend_bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  // Extra MSB holds the sign of the trial subtraction; the shifted remainder may need W+1 bits.
  logic [W+1:0] trial;
  logic         ge;

  always_comb begin
    trial = {1'b0, rem_i, dividend_bit_i} - {2'b00, divisor_i};
    ge    = ~trial[W+1];
    quo_o = W'({quo_i, ge});
    if (ge) begin
      rem_o = W'(trial);
    end else begin
      rem_o = W'({rem_i, dividend_bit_i});
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  div_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic          dbz_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  quotient_q;
  logic [W-1:0]  remainder_q;
  logic          div_by_zero_q;

  logic [W-1:0]  rem_d;
  logic [W-1:0]  quo_d;
  logic [W-1:0]  dvd_mag;
  logic [W-1:0]  dvs_mag;
  logic [W-1:0]  res_quo;
  logic [W-1:0]  res_rem;
  logic          accept;

  assign accept = in_valid & in_ready_q;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q;
  logic neg_rem_q;

  // Magnitudes feed the unsigned core; MIN maps onto 2^(W-1), which still fits in W bits.
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    if (dividend[W-1]) dvd_mag = ~dividend + W'(1);
    if (divisor[W-1])  dvs_mag = ~divisor + W'(1);
  end

  always_comb begin
    res_quo = quo_q;
    res_rem = rem_q;
    if (neg_quo_q) res_quo = ~quo_q + W'(1);
    if (neg_rem_q) res_rem = ~rem_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state_q == IDLE && accept) begin
      neg_quo_q <= dividend[W-1] ^ divisor[W-1];
      neg_rem_q <= dividend[W-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign res_quo = quo_q;
  assign res_rem = rem_q;
`endif

  div_step #(
    .W(W)
  ) u_step (
    .rem_i          (rem_q),
    .quo_i          (quo_q),
    .dividend_bit_i (dvd_q[W-1]),
    .divisor_i      (dvs_q),
    .rem_o          (rem_d),
    .quo_o          (quo_d)
  );

  // Control FSM; DONE spends its first cycle loading the result, then holds it until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dbz_q         <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= dvs_mag;
            cnt_q      <= CW'(W - 1);
            if (divisor == '0) begin
              // Raw dividend is kept so it can be returned as the remainder.
              dbz_q   <= 1'b1;
              dvd_q   <= dividend;
              state_q <= DONE;
            end else begin
              dbz_q   <= 1'b0;
              dvd_q   <= dvd_mag;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          dvd_q <= {dvd_q[W-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            if (dbz_q) begin
              quotient_q    <= W'(DIV_DBZ_QUOTIENT);
              remainder_q   <= dvd_q;
              div_by_zero_q <= 1'b1;
            end else begin
              quotient_q    <= res_quo;
              remainder_q   <= res_rem;
              div_by_zero_q <= 1'b0;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (W=4): directed table, handshake/reset sequences, random ops.
module tb_seq_divider;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division from the arithmetic rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output int lat);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      q   = '1;
      r   = a;
      z   = 1'b1;
      lat = 1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      z   = 1'b0;
      lat = W + 1;
    end
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input int elat, input int hold, input bit noise, input string tag);
    int n;
    bit rdy_bad;
    bit stable_bad;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " in_ready idle"}, longint'(in_ready), 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n        = 0;
    rdy_bad  = 1'b0;
    while (!out_valid && n < 50) begin
      if (in_ready) rdy_bad = 1'b1;
      if (noise) begin
        in_valid = (n >= 1 && n <= 2);
        dividend = ~a;
        divisor  = 4'd1;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, longint'(n), longint'(elat));
    chk({tag, " in_ready busy"}, longint'(rdy_bad), 0);
    chk({tag, " quotient"}, longint'(quotient), longint'(eq));
    chk({tag, " remainder"}, longint'(remainder), longint'(er));
    chk({tag, " div_by_zero"}, longint'(div_by_zero), longint'(ez));
    stable_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!out_valid || in_ready || quotient !== eq || remainder !== er || div_by_zero !== ez)
        stable_bad = 1'b1;
    end
    if (hold > 0) chk({tag, " hold stable"}, longint'(stable_bad), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " handoff valid/ready"}, longint'({out_valid, in_ready}), 1);
    chk({tag, " retained"}, longint'({quotient, remainder, div_by_zero}), longint'({eq, er, ez}));
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           elat;

`ifdef DIV_SIGNED_EN
    vecs.push_back('{a: 4'b1001, b: 4'd2,    q: 4'b1101, r: 4'b1111, z: 1'b0, lat: 5});
    vecs.push_back('{a: 4'd7,    b: 4'b1110, q: 4'b1101, r: 4'd1,    z: 1'b0, lat: 5});
    vecs.push_back('{a: 4'b1000, b: 4'b1111, q: 4'b1000, r: 4'd0,    z: 1'b0, lat: 5});
    vecs.push_back('{a: 4'd7,    b: 4'd0,    q: 4'b1111, r: 4'd7,    z: 1'b1, lat: 1});
    vecs.push_back('{a: 4'd6,    b: 4'd4,    q: 4'd1,    r: 4'd2,    z: 1'b0, lat: 5});
`else
    vecs.push_back('{a: 4'd13, b: 4'd3, q: 4'd4,  r: 4'd1, z: 1'b0, lat: 5});
    vecs.push_back('{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, z: 1'b0, lat: 5});
    vecs.push_back('{a: 4'd0,  b: 4'd7, q: 4'd0,  r: 4'd0, z: 1'b0, lat: 5});
    vecs.push_back('{a: 4'd3,  b: 4'd9, q: 4'd0,  r: 4'd3, z: 1'b0, lat: 5});
    vecs.push_back('{a: 4'd7,  b: 4'd0, q: 4'd15, r: 4'd7, z: 1'b1, lat: 1});
    vecs.push_back('{a: 4'd8,  b: 4'd2, q: 4'd4,  r: 4'd0, z: 1'b0, lat: 5});
    vecs.push_back('{a: 4'd15, b: 4'd15, q: 4'd1, r: 4'd0, z: 1'b0, lat: 5});
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    chk("reset outputs", longint'({in_ready, out_valid, quotient, remainder, div_by_zero}),
        longint'({1'b1, 1'b0, 4'd0, 4'd0, 1'b0}));
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat, 0, 1'b0,
              $sformatf("vec%0d", i));

    // Long consumer stall with in_valid noise during RUN.
    model(4'd13, 4'd3, eq, er, ez, elat);
    run_div(4'd13, 4'd3, eq, er, ez, elat, 6, 1'b1, "stall");

    // Reset in the middle of an operation.
    dividend = 4'd13;
    divisor  = 4'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid-run reset", longint'({in_ready, out_valid, quotient, remainder, div_by_zero}),
        longint'({1'b1, 1'b0, 4'd0, 4'd0, 1'b0}));
    model(4'd9, 4'd2, eq, er, ez, elat);
    run_div(4'd9, 4'd2, eq, er, ez, elat, 0, 1'b0, "after reset");

    // Reset while holding a result in DONE.
    dividend = 4'd11;
    divisor  = 4'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("done reset", longint'({in_ready, out_valid, quotient, remainder, div_by_zero}),
        longint'({1'b1, 1'b0, 4'd0, 4'd0, 1'b0}));

    for (int k = 0; k < 40; k++) begin
      a = W'($urandom_range(0, 15));
      b = W'($urandom_range(0, 15));
      model(a, b, eq, er, ez, elat);
      run_div(a, b, eq, er, ez, elat, int'($urandom_range(0, 2)), 1'b0,
              $sformatf("rand%0d %0d/%0d", k, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
